axi_sub_comp_arb: RTL and testbench

- Shares one component interface (register block or SRAM) between NREQ AXI subordinate-side requesters.
- Each requester presents the same dv/hld/last request bus that an AXI subordinate read/write arbiter drives toward a component.
- Uses round-robin arbitration with burst locking.
- Tracks the component's fixed read latency so that rdata and rd_err are returned to the requester that issued each read.

---
 rtl/axi_pkg.sv | 22 ++
 rtl/axi_sub_comp_arb_rr.sv | 34 +++
 rtl/axi_sub_comp_arb.sv | 170 +++++++++++++++++
 tb/tb_axi_sub_comp_arb.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared definitions for the subordinate-side component arbiter.
//   MAX_NREQ / MAX_IXW : largest supported requester count and its index width
//   MAX_CLAT           : largest supported component read latency
//   arb_state_t        : arbitration FSM state (free arbitration / burst locked)
//   rd_ent_t           : one read-return tracking entry {valid, requester index}
package axi_pkg;

  localparam int MAX_NREQ = 8;
  localparam int MAX_IXW  = 3;
  localparam int MAX_CLAT = 4;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic               valid;
    logic [MAX_IXW-1:0] idx;
  } rd_ent_t;

endpackage

// File: rtl/axi_sub_comp_arb_rr.sv
// Rotating-priority pick: returns the first asserted request found searching
// upward from rr_ptr with wrap-around.
//   req       : request vector, one bit per requester
//   rr_ptr    : index holding highest priority this cycle
//   gnt       : index of the winning requester (0 when none)
//   gnt_valid : at least one request is asserted
module axi_sub_comp_arb_rr #(
  parameter int NREQ = 2,
  parameter int IXW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IXW-1:0]  rr_ptr,
  output logic [IXW-1:0]  gnt,
  output logic            gnt_valid
);

  int unsigned j;

  // NOTE: combinational blocks use blocking assignments and give every output
  // a default first, so no path through the block can infer a latch.
  always_comb begin
    gnt       = '0;
    gnt_valid = 1'b0;
    j         = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = (32'(rr_ptr) + k) % NREQ;
      if (!gnt_valid && req[j]) begin
        gnt       = IXW'(j);
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_sub_comp_arb.sv
// Shares one component request interface between NREQ subordinate-side
// requesters with round-robin arbitration, burst locking and read-return
// routing over the component's fixed read latency.
//   clk, rst        : clock, synchronous active-high reset
//   req_*           : packed per-requester request buses (requester i at slice i)
//   req_hld         : stall back to each requester
//   req_wr_err      : write error, same cycle as the accepted beat
//   req_rvalid/rd_err : read return valid / error for requester i
//   req_rdata       : read data broadcast to every requester
//   dv..last        : request toward the component (mux of the granted requester)
//   hld, rd_err, wr_err, rdata : component stall, errors and read data
module axi_sub_comp_arb
  import axi_pkg::*;
#(
  parameter  int NREQ  = 2,
  parameter  int AW    = 32,
  parameter  int DW    = 32,
  parameter  int UW    = 32,
  parameter  int IW    = 1,
  parameter  int C_LAT = 1,
  localparam int IXW   = $clog2(NREQ),
  localparam int BC    = DW / 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0]    req_dv,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*UW-1:0] req_user,
  input  logic [NREQ*IW-1:0] req_id,
  input  logic [NREQ*DW-1:0] req_wdata,
  input  logic [NREQ*BC-1:0] req_wstrb,
  input  logic [NREQ-1:0]    req_last,
  output logic [NREQ-1:0]    req_hld,
  output logic [NREQ-1:0]    req_wr_err,
  output logic [NREQ-1:0]    req_rvalid,
  output logic [NREQ-1:0]    req_rd_err,
  output logic [DW-1:0]      req_rdata,
  output logic            dv,
  output logic [AW-1:0]   addr,
  output logic            write,
  output logic [UW-1:0]   user,
  output logic [IW-1:0]   id,
  output logic [DW-1:0]   wdata,
  output logic [BC-1:0]   wstrb,
  output logic            last,
  input  logic            hld,
  input  logic            rd_err,
  input  logic            wr_err,
  input  logic [DW-1:0]   rdata
);

  arb_state_t       state;
  logic [IXW-1:0]   rr_ptr, lock_idx, rr_gnt, gnt, ptr_nxt;
  logic             rr_valid, gnt_valid, acc;
  logic [NREQ-1:0]  gnt_oh;
  rd_ent_t          push, pipe_out;

  axi_sub_comp_arb_rr #(.NREQ(NREQ), .IXW(IXW)) u_rr (
    .req       (req_dv),
    .rr_ptr    (rr_ptr),
    .gnt       (rr_gnt),
    .gnt_valid (rr_valid)
  );

  // While locked the grant is frozen, even if the owner misbehaves and drops dv.
  always_comb begin
    gnt       = (state == ST_LOCK) ? lock_idx : rr_gnt;
    gnt_valid = (state == ST_LOCK) || rr_valid;
    dv        = !rst && gnt_valid && req_dv[gnt];
    acc       = dv && !hld;
    ptr_nxt   = (gnt == IXW'(NREQ - 1)) ? '0 : gnt + 1'b1;
  end

  always_comb begin
    addr  = '0;
    write = 1'b0;
    user  = '0;
    id    = '0;
    wdata = '0;
    wstrb = '0;
    last  = 1'b0;
    if (dv) begin
      addr  = req_addr[int'(gnt)*AW +: AW];
      write = req_write[gnt];
      user  = req_user[int'(gnt)*UW +: UW];
      id    = req_id[int'(gnt)*IW +: IW];
      wdata = req_wdata[int'(gnt)*DW +: DW];
      wstrb = req_wstrb[int'(gnt)*BC +: BC];
      last  = req_last[gnt];
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      gnt_oh[i]     = (gnt == IXW'(i));
      req_hld[i]    = hld || !gnt_oh[i];
      req_wr_err[i] = wr_err && gnt_oh[i] && acc && write;
    end
  end

  // A stalled winner locks too, so the grant cannot move under a held beat.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_ARB;
      rr_ptr   <= '0;
      lock_idx <= '0;
    end else begin
      case (state)
        ST_ARB: begin
          if (acc && last) begin
            rr_ptr <= ptr_nxt;
          end else if (dv) begin
            state    <= ST_LOCK;
            lock_idx <= gnt;
          end
        end
        ST_LOCK: begin
          if (acc && last) begin
            state  <= ST_ARB;
            rr_ptr <= ptr_nxt;
          end
        end
        default: state <= ST_ARB;
      endcase
    end
  end

  // Read-return tracking: one entry per cycle, advancing regardless of hld.
  always_comb begin
    push.valid = acc && !write;
    push.idx   = MAX_IXW'(gnt);
  end

  if (C_LAT == 0) begin : g_bypass
    assign pipe_out = push;
  end else begin : g_pipe
    rd_ent_t pipe [C_LAT];
    // NOTE: only the valid bits are reset; the index fields are payload that
    // is ignored until a valid bit reaches them, so they need no reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < C_LAT; k++) pipe[k].valid <= 1'b0;
      end else begin
        pipe[0] <= push;
        for (int k = 1; k < C_LAT; k++) pipe[k] <= pipe[k-1];
      end
    end
    assign pipe_out = pipe[C_LAT-1];
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_rvalid[i] = !rst && pipe_out.valid && (pipe_out.idx == MAX_IXW'(i));
      req_rd_err[i] = rd_err && req_rvalid[i];
    end
  end
  assign req_rdata = rdata;

  a_cfg_range:  assert property (@(posedge clk)
    NREQ >= 2 && NREQ <= MAX_NREQ && C_LAT >= 0 && C_LAT <= MAX_CLAT);
  a_rvalid_oh:  assert property (@(posedge clk) disable iff (rst) $onehot0(req_rvalid));
  a_acc_gnt:    assert property (@(posedge clk) disable iff (rst)
    (req_dv & ~req_hld & ~gnt_oh) == '0);
  a_lock_drop:  assert property (@(posedge clk) disable iff (rst)
    (state == ST_LOCK) |-> req_dv[lock_idx]);

endmodule

// File: tb/tb_axi_sub_comp_arb.sv
module tb_axi_sub_comp_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [1:0] done   = 2'b00;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Two configurations: NREQ=2/C_LAT=1 and NREQ=3/C_LAT=3.
  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int N = (g == 0) ? 2 : 3;
    localparam int L = (g == 0) ? 1 : 3;

    logic rst;
    logic [N-1:0]    req_dv, req_write, req_last, req_hld, req_wr_err, req_rvalid, req_rd_err;
    logic [N*32-1:0] req_addr, req_user, req_wdata;
    logic [N-1:0]    req_id;
    logic [N*4-1:0]  req_wstrb;
    logic [31:0]     req_rdata, addr, user, wdata, rdata;
    logic            dv, write, last, id, hld, rd_err, wr_err;
    logic [3:0]      wstrb;

    axi_sub_comp_arb #(.NREQ(N), .AW(32), .DW(32), .UW(32), .IW(1), .C_LAT(L)) u_dut (
      .clk(clk), .rst(rst),
      .req_dv(req_dv), .req_addr(req_addr), .req_write(req_write), .req_user(req_user),
      .req_id(req_id), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_last(req_last),
      .req_hld(req_hld), .req_wr_err(req_wr_err), .req_rvalid(req_rvalid),
      .req_rd_err(req_rd_err), .req_rdata(req_rdata),
      .dv(dv), .addr(addr), .write(write), .user(user), .id(id), .wdata(wdata),
      .wstrb(wstrb), .last(last), .hld(hld), .rd_err(rd_err), .wr_err(wr_err), .rdata(rdata)
    );

    typedef struct { int len; bit wr; bit err; } burst_t;
    typedef struct {
      int cyc; bit chk_hld; logic [N-1:0] hld_v; logic dv; logic acc;
      logic [102:0] beat; logic [N-1:0] wr_err;
    } cyc_exp_t;
    typedef struct { int cyc; logic [N-1:0] rv; logic [N-1:0] re; logic [31:0] data; } rd_exp_t;
    typedef struct { int cyc; logic [31:0] a; } comp_t;

    burst_t   bq [N][$];
    cyc_exp_t pq [$];
    rd_exp_t  rq [$];
    comp_t    cq [$];

    bit          cur_v [N];
    bit          cur_wr [N], cur_err [N];
    int          cur_len [N], cur_beat [N];
    logic [31:0] cur_wdata [N], cur_user [N];
    logic        cur_id [N];
    logic [3:0]  cur_wstrb [N];

    // Reference model state: owner of an unfinished/stalled beat, priority pointer.
    int owner = -1;
    int ptr   = 0;
    int cyc   = 0;
    bit rst_drv = 1'b1, hld_rand = 1'b0, wr_err_force = 1'b0;
    int hld_force = 0;

    function automatic logic [102:0] beat_of(int i);
      return {32'(i*4096 + cur_beat[i]*16 + (cur_err[i] ? 4 : 0)), cur_wr[i], cur_wdata[i],
              (cur_beat[i] == cur_len[i] - 1), cur_id[i], cur_user[i], cur_wstrb[i]};
    endfunction

    task automatic new_beat(int i);
      cur_wdata[i] = $urandom;
      cur_user[i]  = $urandom;
      cur_id[i]    = 1'($urandom_range(0, 1));
      cur_wstrb[i] = 4'($urandom_range(0, 15));
    endtask

    task automatic drive_req(int i);
      logic [102:0] b;
      b = beat_of(i);
      req_dv[i]               = cur_v[i];
      req_addr[i*32 +: 32]    = b[102:71];
      req_write[i]            = b[70];
      req_wdata[i*32 +: 32]   = b[69:38];
      req_last[i]             = b[37];
      req_id[i]               = b[36];
      req_user[i*32 +: 32]    = b[35:4];
      req_wstrb[i*4 +: 4]     = b[3:0];
    endtask

    task automatic model();
      cyc_exp_t    e;
      rd_exp_t     r;
      int          w;
      logic [N-1:0] oh;
      e.cyc = cyc; e.chk_hld = 1'b0; e.hld_v = '0; e.dv = 1'b0; e.acc = 1'b0;
      e.beat = '0; e.wr_err = '0;
      if (rst) begin
        pq.push_back(e);
        owner = -1; ptr = 0;
        rq.delete(); cq.delete();
        for (int i = 0; i < N; i++) begin cur_v[i] = 1'b0; bq[i].delete(); end
        return;
      end
      w = owner;
      if (w < 0)
        for (int k = 0; k < N; k++)
          if (w < 0 && cur_v[(ptr + k) % N]) w = (ptr + k) % N;
      if (w >= 0) begin
        oh        = N'(1) << w;
        e.chk_hld = 1'b1;
        e.hld_v   = hld ? '1 : ~oh;
        e.dv      = cur_v[w];
        e.acc     = e.dv && !hld;
        if (e.acc) begin
          e.beat = beat_of(w);
          if (cur_wr[w] && wr_err) e.wr_err = oh;
          if (!cur_wr[w]) begin
            r.cyc = cyc + L; r.rv = oh; r.re = cur_err[w] ? oh : '0;
            r.data = 32'hA5A5_0000 + 32'(w);
            rq.push_back(r);
          end
          if (cur_beat[w] == cur_len[w] - 1) begin
            owner = -1; ptr = (w + 1) % N;
          end else begin
            owner = w;
          end
          cur_beat[w]++;
          if (cur_beat[w] == cur_len[w]) cur_v[w] = 1'b0;
          else new_beat(w);
        end else if (e.dv) begin
          owner = w;
        end
      end
      pq.push_back(e);
    endtask

    task automatic step();
      comp_t c;
      burst_t b;
      @(posedge clk); #1;
      cyc++;
      if (cq.size() > 0 && cq[0].cyc == cyc) begin
        c = cq.pop_front();
        rdata  = 32'hA5A5_0000 + {28'h0, c.a[15:12]};
        rd_err = c.a[2];
      end else begin
        rdata  = $urandom;
        rd_err = 1'($urandom_range(0, 1));
      end
      hld    = (hld_force > 0) ? 1'b1 : (hld_rand && $urandom_range(0, 3) == 0);
      if (hld_force > 0) hld_force--;
      wr_err = wr_err_force ? 1'b1 : 1'($urandom_range(0, 1));
      rst    = rst_drv;
      for (int i = 0; i < N; i++) begin
        if (!cur_v[i] && bq[i].size() > 0) begin
          b = bq[i].pop_front();
          cur_v[i] = 1'b1; cur_len[i] = b.len; cur_beat[i] = 0;
          cur_wr[i] = b.wr; cur_err[i] = b.err;
          new_beat(i);
        end
        drive_req(i);
      end
      model();
    endtask

    function automatic bit busy();
      bit bz = (rq.size() > 0);
      for (int i = 0; i < N; i++) if (cur_v[i] || bq[i].size() > 0) bz = 1'b1;
      return bz;
    endfunction

    task automatic drain();
      int t = 0;
      while (t < 300 && busy()) begin step(); t++; end
      check($sformatf("cfg%0d.drain_timeout", g), 128'(busy()), 128'(0));
    endtask

    // Scoreboard monitor, sampling between active edges.
    always @(negedge clk) begin
      cyc_exp_t e;
      rd_exp_t  r;
      comp_t    c;
      if (pq.size() > 0) begin
        e = pq.pop_front();
        check($sformatf("cfg%0d.c%0d.dv", g, e.cyc), 128'(dv), 128'(e.dv));
        if (e.chk_hld) check($sformatf("cfg%0d.c%0d.req_hld", g, e.cyc), 128'(req_hld), 128'(e.hld_v));
        if (e.acc) check($sformatf("cfg%0d.c%0d.beat", g, e.cyc),
                         128'({addr, write, wdata, last, id, user, wstrb}), 128'(e.beat));
        check($sformatf("cfg%0d.c%0d.req_wr_err", g, e.cyc), 128'(req_wr_err), 128'(e.wr_err));
        if (dv && !hld && !write) begin
          c.cyc = cyc + L; c.a = addr;
          cq.push_back(c);
        end
      end
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        r = rq.pop_front();
        check($sformatf("cfg%0d.c%0d.req_rvalid", g, cyc), 128'(req_rvalid), 128'(r.rv));
        check($sformatf("cfg%0d.c%0d.req_rd_err", g, cyc), 128'(req_rd_err), 128'(r.re));
        check($sformatf("cfg%0d.c%0d.req_rdata", g, cyc), 128'(req_rdata), 128'(r.data));
      end else if (cyc > 0) begin
        check($sformatf("cfg%0d.c%0d.no_return", g, cyc), 128'({req_rvalid, req_rd_err}), 128'(0));
      end
    end

    initial begin
      burst_t b;
      rst = 1'b1; hld = 1'b0; rd_err = 1'b0; wr_err = 1'b0; rdata = '0;
      req_dv = '0; req_addr = '0; req_write = '0; req_user = '0; req_id = '0;
      req_wdata = '0; req_wstrb = '0; req_last = '0;
      for (int i = 0; i < N; i++) cur_v[i] = 1'b0;
      repeat (3) step();
      rst_drv = 1'b0;
      step();

      // Single-beat reads from requesters 0 and 1 every cycle.
      for (int k = 0; k < 4; k++) begin
        b = '{len: 1, wr: 1'b0, err: 1'b0};
        bq[0].push_back(b); bq[1].push_back(b);
      end
      drain();

      // Burst lock: 4-beat write from 0 against a pending read from 1.
      b = '{len: 4, wr: 1'b1, err: 1'b0}; bq[0].push_back(b);
      b = '{len: 1, wr: 1'b0, err: 1'b0}; bq[1].push_back(b);
      drain();

      // Stall: requester 1 granted under hld for 3 cycles while 0 rises.
      b = '{len: 1, wr: 1'b1, err: 1'b0}; bq[1].push_back(b);
      hld_force = 3;
      step();
      b = '{len: 1, wr: 1'b0, err: 1'b0}; bq[0].push_back(b);
      drain();

      // Write error on an accepted write from requester 1.
      b = '{len: 1, wr: 1'b1, err: 1'b0}; bq[1].push_back(b);
      wr_err_force = 1'b1;
      step();
      wr_err_force = 1'b0;
      drain();

      // Latency routing: reads from N-1, 0, 1 back-to-back, error on the second.
      if (N >= 3) begin
        b = '{len: 1, wr: 1'b0, err: 1'b0}; bq[N-1].push_back(b); step();
        b = '{len: 1, wr: 1'b0, err: 1'b1}; bq[0].push_back(b);   step();
        b = '{len: 1, wr: 1'b0, err: 1'b0}; bq[1].push_back(b);
        drain();
      end

      // Reset during beat 2 of a burst from requester 1, read from 0 in flight.
      b = '{len: 1, wr: 1'b0, err: 1'b0}; bq[0].push_back(b); step();
      b = '{len: 4, wr: 1'b1, err: 1'b0}; bq[1].push_back(b); step();
      rst_drv = 1'b1; step();
      rst_drv = 1'b0;
      b = '{len: 1, wr: 1'b1, err: 1'b0};
      bq[0].push_back(b); bq[1].push_back(b);
      drain();

      // Randomised traffic with random component stalls.
      hld_rand = 1'b1;
      for (int t = 0; t < 400; t++) begin
        for (int i = 0; i < N; i++)
          if (!cur_v[i] && bq[i].size() == 0 && $urandom_range(0, 2) == 0) begin
            b.len = $urandom_range(1, 4);
            b.wr  = 1'($urandom_range(0, 1));
            b.err = 1'($urandom_range(0, 1));
            bq[i].push_back(b);
          end
        step();
      end
      hld_rand = 1'b0;
      drain();
      done[g] = 1'b1;
    end
  end

  initial begin
    for (int t = 0; t < 60000 && done != 2'b11; t++) @(posedge clk);
    check("all_configs_done", 128'(done), 128'(2'b11));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
